// File: rtl/scp_pkg.sv
// Shared encodings, FSM state type and reset default for the SCP fetch path.
package scp_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Next-PC select, driven by the controller with instrTaken.
    localparam logic [1:0] pcSel_PC4     = 2'b00;
    localparam logic [1:0] pcSel_BRANCH  = 2'b01;
    localparam logic [1:0] pcSel_JAL     = 2'b10;
    localparam logic [1:0] pcSel_ILLEGAL = 2'b11;

    // Register-file write-back select; PC4 takes the link value from pcPlus4.
    localparam logic [1:0] regFileWrSel_ALU = 2'b00;
    localparam logic [1:0] regFileWrSel_MEM = 2'b01;
    localparam logic [1:0] regFileWrSel_PC4 = 2'b10;
    localparam logic [1:0] regFileWrSel_IMM = 2'b11;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        VALID = 2'b01,
        HALT  = 2'b10
    } fetch_state_e;

    // Signed 16-bit word offset scaled to a 32-bit byte offset.
    function automatic logic [31:0] word_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/scp_next_pc.sv
// Combinational next-PC selection for the fetch unit; all sums wrap modulo 2^32.
module scp_next_pc
    import scp_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pcSel,
    input  logic [15:0] imm,
    input  logic [31:0] rs1Val,
    output logic [31:0] nextPc,
    output logic        illegal
);

    logic [31:0] pc_plus4;
    logic [31:0] offset;

    assign pc_plus4 = pc + 32'd4;
    assign offset   = word_offset(imm);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        nextPc  = pc_plus4;
        illegal = 1'b0;
        case (pcSel)
            pcSel_PC4:    nextPc = pc_plus4;
            pcSel_BRANCH: nextPc = pc_plus4 + offset;
            pcSel_JAL:    nextPc = rs1Val + offset;
            default: begin
                nextPc  = pc_plus4;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/scp_fetch_unit.sv
// Two-phase instruction fetch (FETCH -> VALID) with next-PC update on retire.
// SCP_FETCH_ALIGN_CHECK_EN enables the sticky misalignment fault and HALT state.
module scp_fetch_unit
    import scp_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemRdata,
    output logic [31:0] instruction,
    output logic        instrValid,
    input  logic        instrTaken,
    input  logic [1:0]  pcSel,
    input  logic [15:0] imm,
    input  logic [31:0] rs1Val,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        illegalPcSel,
    output logic        misaligned
);

`ifdef SCP_FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    fetch_state_e state_q;
    logic [31:0]  pc_q, instr_q, raw_next_pc, pc_d;
    logic         req_q, valid_q, illegal_q, misaligned_q;
    logic         illegal_sel, fault;

    scp_next_pc u_next_pc (
        .pc      (pc_q),
        .pcSel   (pcSel),
        .imm     (imm),
        .rs1Val  (rs1Val),
        .nextPc  (raw_next_pc),
        .illegal (illegal_sel)
    );

    // Without the check, low bits are silently dropped so a fault can never occur.
    assign fault = ALIGN_CHECK && (raw_next_pc[1:0] != 2'b00);
    assign pc_d  = ALIGN_CHECK ? raw_next_pc : {raw_next_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            req_q        <= 1'b1;
            valid_q      <= 1'b0;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (imemAck) begin
                        instr_q <= imemRdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= VALID;
                    end
                end
                VALID: begin
                    if (instrTaken) begin
                        valid_q <= 1'b0;
                        if (fault) begin
                            misaligned_q <= 1'b1;
                            state_q      <= HALT;
                        end else begin
                            pc_q      <= pc_d;
                            illegal_q <= illegal_sel;
                            req_q     <= 1'b1;
                            state_q   <= FETCH;
                        end
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imemReq      = req_q;
    assign imemAddr     = pc_q;
    assign instruction  = instr_q;
    assign instrValid   = valid_q;
    assign pc           = pc_q;
    assign pcPlus4      = pc_q + 32'd4;
    assign illegalPcSel = illegal_q;
    assign misaligned   = misaligned_q;

endmodule

// File: tb/tb_scp_fetch_unit.sv
// Self-checking bench for scp_fetch_unit: directed corner cases then randomized
// fetch/retire traffic against a PC reference model.
`timescale 1ns/1ps
module tb_scp_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, imemReq, imemAck, instrValid, instrTaken;
    logic        illegalPcSel, misaligned;
    logic [31:0] imemAddr, imemRdata, instruction, rs1Val, pc, pcPlus4;
    logic [1:0]  pcSel;
    logic [15:0] imm;

    int          n_checks = 0, n_pass = 0, n_fail = 0;
    logic [31:0] model_pc, last_word;
    bit          halted;

    always #5 clk = ~clk;

    scp_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemAck(imemAck), .imemRdata(imemRdata), .instruction(instruction),
        .instrValid(instrValid), .instrTaken(instrTaken), .pcSel(pcSel),
        .imm(imm), .rs1Val(rs1Val), .pc(pc), .pcPlus4(pcPlus4),
        .illegalPcSel(illegalPcSel), .misaligned(misaligned)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference next PC straight from the selection rules, using signed integer math.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] sel,
                                               input logic [15:0] im, input logic [31:0] rs1);
        shortint     s   = shortint'(im);
        int          off = int'(s) * 4;
        logic [31:0] r;
        case (sel)
            2'd1:    r = cur + 32'd4 + 32'(off);
            2'd2:    r = rs1 + 32'(off);
            default: r = cur + 32'd4;
        endcase
`ifndef SCP_FETCH_ALIGN_CHECK_EN
        r[1:0] = 2'b00;
`endif
        return r;
    endfunction

    // Complete one fetch, optionally stalling and poking instrTaken while it waits.
    task automatic fetch(input logic [31:0] word, input int stall, input bit poke);
        check("fetch_req", imemReq, 1);
        check("fetch_addr", imemAddr, model_pc);
        check("fetch_valid0", instrValid, 0);
        for (int i = 0; i < stall; i++) begin
            imemAck    = 1'b0;
            instrTaken = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            pcSel      = 2'($urandom);
            tick;
            check("stall_req", imemReq, 1);
            check("stall_addr", imemAddr, model_pc);
            check("stall_valid", instrValid, 0);
        end
        instrTaken = 1'b0;
        imemAck    = 1'b1;
        imemRdata  = word;
        tick;
        imemAck    = 1'b0;
        last_word  = word;
        check("valid_up", instrValid, 1);
        check("instr", instruction, word);
        check("pc_held", pc, model_pc);
        check("pc_plus4", pcPlus4, model_pc + 32'd4);
    endtask

    // Retire the held instruction; optionally first prove a stray imemAck is ignored.
    task automatic retire(input logic [1:0] sel, input logic [15:0] im, input logic [31:0] rs1,
                          input bit poke);
        logic [31:0] exp;
        if (poke) begin
            imemAck   = 1'b1;
            imemRdata = ~last_word;
            tick;
            imemAck   = 1'b0;
            check("ack_ignored", instruction, last_word);
            check("valid_hold", instrValid, 1);
        end
        exp        = model_next(model_pc, sel, im, rs1);
        instrTaken = 1'b1;
        pcSel      = sel;
        imm        = im;
        rs1Val     = rs1;
        tick;
        instrTaken = 1'b0;
        check("valid_down", instrValid, 0);
        if (exp[1:0] != 2'b00) begin
            halted = 1'b1;
            check("halt_misaligned", misaligned, 1);
            check("halt_req", imemReq, 0);
            check("halt_pc", pc, model_pc);
        end else begin
            model_pc = exp;
            check("illegal_pulse", illegalPcSel, (sel == 2'b11) ? 1 : 0);
            check("next_addr", imemAddr, model_pc);
            check("no_misaligned", misaligned, 0);
        end
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        imemAck    = 1'b0;
        instrTaken = 1'b0;
        tick;
        tick;
        reset    = 1'b0;
        model_pc = 32'h0;
        halted   = 1'b0;
        check("rst_misaligned", misaligned, 0);
        check("rst_pc", pc, 0);
    endtask

    initial begin
        reset = 1'b1; imemAck = 1'b1; imemRdata = 32'h1111_0013;
        instrTaken = 1'b0; pcSel = 2'b00; imm = '0; rs1Val = '0; halted = 1'b0;
        model_pc = 32'h0; last_word = 32'h0;
        tick;
        tick;
        check("rst_pc", pc, 0);
        check("rst_instr", instruction, 0);
        check("rst_valid", instrValid, 0);
        check("rst_illegal", illegalPcSel, 0);
        check("rst_misaligned", misaligned, 0);

        // Release with imemAck held high: request now, instruction next cycle.
        reset = 1'b0;
        check("c1_req", imemReq, 1);
        check("c1_addr", imemAddr, 0);
        tick;
        imemAck   = 1'b0;
        last_word = 32'h1111_0013;
        check("c2_valid", instrValid, 1);
        check("c2_instr", instruction, 32'h1111_0013);
        retire(2'b00, 16'h0, 32'h0, 1'b0);
        check("pc_after_first", pc, 32'h4);

        // Reset racing a same-cycle ack during FETCH.
        reset = 1'b1; imemAck = 1'b1; imemRdata = 32'hDEAD_BEEF;
        tick;
        reset = 1'b0; imemAck = 1'b0; model_pc = 32'h0;
        check("rstack_instr", instruction, 0);
        check("rstack_valid", instrValid, 0);
        check("rstack_pc", pc, 0);

        // Taken backward branch from 0x100.
        fetch(32'hA000_0001, 0, 1'b0);
        retire(2'b10, 16'h0, 32'h100, 1'b0);
        fetch(32'hA000_0002, 0, 1'b0);
        retire(2'b01, 16'hFFFE, 32'h0, 1'b0);
        check("branch_addr", imemAddr, 32'hFC);

        // JAL from 0x20 with link value visible while valid.
        fetch(32'hA000_0003, 0, 1'b0);
        retire(2'b10, 16'h0, 32'h20, 1'b0);
        fetch(32'hA000_0004, 0, 1'b0);
        check("jal_link", pcPlus4, 32'h24);
        retire(2'b10, 16'h3, 32'h400, 1'b0);
        check("jal_addr", imemAddr, 32'h40C);

        // Memory stalled for five cycles.
        fetch(32'hA000_0005, 5, 1'b0);

        // Illegal select at 0x8.
        retire(2'b10, 16'h0, 32'h8, 1'b0);
        fetch(32'hA000_0006, 0, 1'b0);
        retire(2'b11, 16'h7, 32'h0, 1'b0);
        check("illegal_pc", imemAddr, 32'hC);
        tick;
        check("illegal_drop", illegalPcSel, 0);

        // Address wrap past the top of memory.
        fetch(32'hA000_0007, 1, 1'b0);
        retire(2'b10, 16'h0, 32'hFFFF_FFFC, 1'b0);
        fetch(32'hA000_0008, 0, 1'b0);
        retire(2'b00, 16'h0, 32'h0, 1'b0);
        check("wrap_addr", imemAddr, 32'h0);

        // Misaligned JAL target.
        fetch(32'hA000_0009, 0, 1'b0);
        retire(2'b10, 16'h0, 32'h402, 1'b0);
`ifdef SCP_FETCH_ALIGN_CHECK_EN
        check("halt_entered", halted, 1);
        for (int i = 0; i < 4; i++) begin
            imemAck = 1'b1; instrTaken = 1'b1;
            tick;
            check("halt_no_req", imemReq, 0);
            check("halt_no_valid", instrValid, 0);
            check("halt_sticky", misaligned, 1);
        end
        imemAck = 1'b0; instrTaken = 1'b0;
`else
        check("mask_addr", imemAddr, 32'h400);
`endif
        do_reset;

        // Randomized traffic with stray acks and retires.
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  sel;
            logic [15:0] im;
            logic [31:0] rs1;
            sel = 2'($urandom);
            im  = 16'($urandom);
            rs1 = $urandom;
`ifdef SCP_FETCH_ALIGN_CHECK_EN
            rs1[1:0] = 2'b00;
`endif
            fetch($urandom, $urandom_range(0, 3), 1'b1);
            retire(sel, im, rs1, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scp_fetch_unit.md
SCP_FETCH_UNIT -- requirements
Module: scp_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, byte address fetched first after reset.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: imemReq  out  1  instruction-memory read request.
REQ-005 SHALL have ports: imemAddr  out  32  word-aligned byte address of the request.
REQ-006 SHALL have ports: imemAck  in  1  memory returns imemRdata this cycle.
REQ-007 SHALL have ports: imemRdata  in  32  fetched instruction word.
REQ-008 SHALL have ports: instruction  out  32  instruction presented to the controller.
REQ-009 SHALL have ports: instrValid  out  1  instruction, pc, pcPlus4 are valid.
REQ-010 SHALL have ports: instrTaken  in  1  datapath retires the instruction; pcSel, imm, rs1Val valid.
REQ-011 SHALL have ports: pcSel  in  2  00 PC+4, 01 PC+4+imm, 10 rs1+imm, 11 illegal.
REQ-012 SHALL have ports: imm  in  16  signed word offset from the instruction.
REQ-013 SHALL have ports: rs1Val  in  32  register-file read-port-0 value, used for JAL.
REQ-014 SHALL have ports: pc  out  32  address of the held instruction.
REQ-015 SHALL have ports: pcPlus4  out  32  pc+4, the link value for regFileWrSel_PC4.
REQ-016 SHALL have ports: illegalPcSel  out  1  one-cycle pulse when pcSel=11 is retired.
REQ-017 SHALL have ports: misaligned  out  1  sticky alignment fault (macro-dependent).

Function
REQ-018 SHALL implement FSM states FETCH, VALID and HALT.
REQ-019 FETCH SHALL hold imemReq=1 and imemAddr=pc stable until imemAck=1, then latch imemRdata into instruction and move to VALID next cycle.
REQ-020 imemAck in the same cycle as the first imemReq SHALL be legal; instrValid SHALL rise on the following cycle.
REQ-021 VALID SHALL hold instrValid=1 with instruction and pc stable until instrTaken=1.
REQ-022 On instrTaken, pc SHALL load the next PC and the FSM SHALL return to FETCH next cycle.
REQ-023 The minimum issue rate SHALL be one instruction per 2 cycles.
REQ-024 Next PC for 00 SHALL be pc+4.
REQ-025 Next PC for 01 SHALL be pc+4+(sext(imm)<<2).
REQ-026 Next PC for 10 SHALL be rs1Val+(sext(imm)<<2).
REQ-027 Next PC for 11 SHALL be pc+4, and illegalPcSel SHALL pulse.
REQ-028 All PC arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC+4 gives 0.
REQ-029 imemAck outside FETCH SHALL be ignored.
REQ-030 instrTaken outside VALID SHALL be ignored.
REQ-031 pcPlus4 SHALL be combinational pc+4.

Reset
REQ-032 reset SHALL win over every simultaneous event.
REQ-033 Reset state: pc=RESET_PC, FSM=FETCH, instruction=0, instrValid=0, illegalPcSel=0, misaligned=0.
REQ-034 imemReq SHALL be 1 in the first cycle after reset deasserts.
REQ-035 Reset during FETCH SHALL discard a same-cycle imemAck; the fetch SHALL restart at RESET_PC.

Configuration
REQ-036 With SCP_FETCH_ALIGN_CHECK_EN defined, a retired next PC with bits[1:0]!=0 SHALL set misaligned, enter HALT and leave pc at the faulting instruction.
REQ-037 HALT SHALL hold imemReq=0 and instrValid=0, and SHALL be left only by reset.
REQ-038 Without SCP_FETCH_ALIGN_CHECK_EN, next-PC bits[1:0] SHALL be forced to 0, misaligned SHALL be tied 0, and HALT SHALL be unreachable.

Structure
REQ-039 Shared package scp_pkg SHALL hold the pcSel_* and regFileWrSel_* encodings, the FSM state typedef and the RESET_PC default.
REQ-040 Next-PC arithmetic SHALL live in combinational sub-module scp_next_pc, inputs pc/pcSel/imm/rs1Val, outputs nextPc/illegal.

Verification
REQ-041 The bench SHALL cover reset release with imemAck held at 1: imemAddr=0 on cycle 1, instrValid=1 on cycle 2, then pc=4 after instrTaken with pcSel=00.
REQ-042 The bench SHALL cover a taken branch: pc=32'h100, pcSel=01, imm=16'hFFFE, retired -> next imemAddr=32'hFC.
REQ-043 The bench SHALL cover JAL: pc=32'h20, rs1Val=32'h400, imm=3, pcSel=10 -> imemAddr=32'h40C; pcPlus4=32'h24 while instrValid=1.
REQ-044 The bench SHALL cover a stalled memory: imemAck withheld 5 cycles -> imemReq/imemAddr stable, instrValid=0; then one cycle after the ack, instruction equals imemRdata.
REQ-045 The bench SHALL cover pcSel=11 at pc=32'h8 -> illegalPcSel pulses 1 cycle and next pc=32'hC.
REQ-046 The bench SHALL cover macro defined, rs1Val=32'h402, imm=0, pcSel=10 -> misaligned=1, HALT, no imemReq until reset; macro undefined -> imemAddr=32'h400.
